// File: rtl/nf_mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states, opcodes,
// immediate-format and ALU-op codes. HALT exists only when NF_MC_ILL_TRAP_EN is defined.
package nf_mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
`ifdef NF_MC_ILL_TRAP_EN
        S_WB,
        S_HALT
`else
        S_WB
`endif
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] I_SEL = 2'b00;
    localparam logic [1:0] U_SEL = 2'b01;
    localparam logic [1:0] B_SEL = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

endpackage

// File: rtl/nf_mc_ctrl_dec.sv
// Combinational opcode classifier: instruction class flags plus the immediate
// format, operand-B select and ALU-op code each opcode implies.
module nf_mc_ctrl_dec
    import nf_mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       known,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic [1:0] imm_src,
    output logic       store_fmt,
    output logic       srcb_imm,
    output logic [1:0] alu_op
);

    always_comb begin
        known     = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        imm_src   = I_SEL;
        store_fmt = 1'b0;
        srcb_imm  = 1'b1;
        alu_op    = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                srcb_imm = 1'b0;
                alu_op   = ALU_FUNCT;
            end
            OPC_OPIMM: alu_op = ALU_FUNCT;
            OPC_LUI: begin
                imm_src = U_SEL;
                alu_op  = ALU_PASSB;
            end
            OPC_LOAD:  is_load = 1'b1;
            OPC_STORE: begin
                is_store  = 1'b1;
                store_fmt = 1'b1;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                imm_src   = B_SEL;
                srcb_imm  = 1'b0;
                alu_op    = ALU_SUB;
            end
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/nf_mc_ctrl.sv
// Multi-cycle RV32 control FSM with memory-ack timeout counter.
// Define NF_MC_ILL_TRAP_EN to trap unknown opcodes into HALT instead of retiring them as NOPs.
module nf_mc_ctrl
    import nf_mc_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TO = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        instr_we,
    output logic [1:0]  imm_src,
    output logic        store_fmt,
    output logic        srcb_imm,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic        wd_src,
    output logic        pc_we,
    output logic        pc_src,
    output logic        mem_err,
    output logic        illegal
);

    localparam logic [7:0] ACK_LIM = 8'(ACK_TO - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       req_phase, timeout;

    logic       d_known, d_load, d_store, d_branch, d_store_fmt, d_srcb_imm;
    logic [1:0] d_imm_src, d_alu_op;

    logic unused_instr;
    assign unused_instr = ^{instr[31:13], instr[11:7]};

    nf_mc_ctrl_dec u_dec (
        .opcode    (instr[6:0]),
        .known     (d_known),
        .is_load   (d_load),
        .is_store  (d_store),
        .is_branch (d_branch),
        .imm_src   (d_imm_src),
        .store_fmt (d_store_fmt),
        .srcb_imm  (d_srcb_imm),
        .alu_op    (d_alu_op)
    );

    // Timeout fires on the last waiting cycle; an ack in that same cycle still completes.
    assign req_phase = (state == S_FETCH) || (state == S_MEM);
    assign timeout   = req_phase && !mem_ack && (wait_cnt == ACK_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || mem_ack || !req_phase || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        instr_we  = 1'b0;
        imm_src   = I_SEL;
        store_fmt = 1'b0;
        srcb_imm  = 1'b0;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wd_src    = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        mem_err   = 1'b0;
        illegal   = 1'b0;

        if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
            imm_src   = d_imm_src;
            store_fmt = d_store_fmt;
        end

        case (state)
            S_FETCH: begin
                if (timeout) begin
                    mem_err = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        instr_we  = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (d_known)
                    state_nxt = S_EXEC;
                else
`ifdef NF_MC_ILL_TRAP_EN
                    state_nxt = S_HALT;
`else
                    state_nxt = S_WB;
`endif
            end
            S_EXEC: begin
                srcb_imm = d_srcb_imm;
                alu_op   = d_alu_op;
                if (d_branch) begin
                    pc_we     = 1'b1;
                    pc_src    = zero ^ instr[12];
                    state_nxt = S_FETCH;
                end else if (d_load || d_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (timeout) begin
                    mem_err   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = d_store;
                    if (mem_ack) begin
                        if (d_load) begin
                            state_nxt = S_WB;
                        end else begin
                            pc_we     = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                end
            end
            S_WB: begin
                rf_we     = d_known;
                pc_we     = 1'b1;
                wd_src    = d_load;
                state_nxt = S_FETCH;
            end
`ifdef NF_MC_ILL_TRAP_EN
            S_HALT: illegal = 1'b1;
`endif
            default: state_nxt = S_FETCH;
        endcase

        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            instr_we  = 1'b0;
            imm_src   = '0;
            store_fmt = 1'b0;
            srcb_imm  = 1'b0;
            alu_op    = '0;
            rf_we     = 1'b0;
            wd_src    = 1'b0;
            pc_we     = 1'b0;
            pc_src    = 1'b0;
            mem_err   = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_nf_mc_ctrl.sv
// Bench for nf_mc_ctrl: per-instruction cycle timelines are built from the
// instruction-level rules, then played against the DUT cycle by cycle.
module tb_nf_mc_ctrl;

    localparam int unsigned ACK_TO = 16;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ack;
    logic [31:0] instr;
    logic        mem_req, mem_we, instr_we, store_fmt, srcb_imm;
    logic        rf_we, wd_src, pc_we, pc_src, mem_err, illegal;
    logic [1:0]  imm_src, alu_op;

    nf_mc_ctrl #(.ACK_TO(ACK_TO)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .instr_we(instr_we), .imm_src(imm_src),
        .store_fmt(store_fmt), .srcb_imm(srcb_imm), .alu_op(alu_op), .rf_we(rf_we),
        .wd_src(wd_src), .pc_we(pc_we), .pc_src(pc_src), .mem_err(mem_err),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // One expected clock cycle: inputs to apply and outputs required.
    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] ins;
        logic        z;
        logic [8:0]  strb;   // {req,we,iwe,rfwe,pcwe,pcsrc,wdsrc,err,ill}
        logic        chk_dec;
        logic [1:0]  imm;
        logic        sfmt;
        logic        chk_exe;
        logic [1:0]  aop;
        logic        srcb;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LUI  = 32'h12345137;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] BNE  = 32'h00001463;
    localparam logic [31:0] LW   = 32'h0000A183;
    localparam logic [31:0] SW   = 32'h0020A023;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] ILL  = 32'h0000007F;

    // 0 R, 1 OP-IMM, 2 LUI, 3 LOAD, 4 STORE, 5 BRANCH, 6 unknown
    function automatic int cls_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h33:   return 0;
            7'h13:   return 1;
            7'h37:   return 2;
            7'h03:   return 3;
            7'h23:   return 4;
            7'h63:   return 5;
            default: return 6;
        endcase
    endfunction

    function automatic logic [8:0] mk(input logic req, we, iwe, rfwe, pcwe, pcsrc, wdsrc, err, ill);
        return {req, we, iwe, rfwe, pcwe, pcsrc, wdsrc, err, ill};
    endfunction

    function automatic cyc_t blank(input logic [31:0] ins, input logic z, input logic a);
        cyc_t c;
        c.rst = 1'b0; c.ack = a; c.ins = ins; c.z = z; c.strb = '0;
        c.chk_dec = 1'b0; c.imm = '0; c.sfmt = 1'b0;
        c.chk_exe = 1'b0; c.aop = '0; c.srcb = 1'b0;
        return c;
    endfunction

    // Ack level in states where the controller must ignore it: 0, 1, or 2 = random.
    function automatic logic idle_ack(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'(mode);
    endfunction

    task automatic push_reset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(32'(ILL), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            c.rst = 1'b1;
            q.push_back(c);
        end
    endtask

    task automatic push_fetch_timeout();
        cyc_t c;
        for (int i = 0; i < int'(ACK_TO) - 1; i++) begin
            c = blank('0, 1'b0, 1'b0);
            c.strb = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
            q.push_back(c);
        end
        c = blank('0, 1'b0, 1'b0);
        c.strb = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        q.push_back(c);
    endtask

    // mem_abort: -1 normal, -2 ack never arrives in MEM, n>=0 reset at MEM wait cycle n.
    task automatic push_instr(input logic [31:0] ins, input logic z, input int df,
                              input int dm, input int idle, input int mem_abort);
        cyc_t       c;
        int         k;
        logic [1:0] imm, aop;
        logic       sf, sb;
        k   = cls_of(ins);
        imm = (k == 2) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
        sf  = (k == 4);
        aop = (k == 0 || k == 1) ? 2'b10 : (k == 2) ? 2'b11 : (k == 5) ? 2'b01 : 2'b00;
        sb  = !(k == 0 || k == 5);

        for (int i = 0; i <= df; i++) begin
            c = blank(ins, z, i == df);
            c.strb = mk(1, 0, i == df, 0, 0, 0, 0, 0, 0);
            q.push_back(c);
        end

        c = blank(ins, z, idle_ack(idle));
        c.chk_dec = 1'b1; c.imm = imm; c.sfmt = sf;
        q.push_back(c);

        if (k == 6) begin
`ifdef NF_MC_ILL_TRAP_EN
            for (int i = 0; i < 3; i++) begin
                c = blank(ins, z, idle_ack(idle));
                c.strb = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
                q.push_back(c);
            end
            push_reset(1);
`else
            c = blank(ins, z, idle_ack(idle));
            c.strb = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
            c.chk_dec = 1'b1; c.imm = 2'b00; c.sfmt = 1'b0;
            q.push_back(c);
`endif
            return;
        end

        c = blank(ins, z, idle_ack(idle));
        c.chk_dec = 1'b1; c.imm = imm; c.sfmt = sf;
        c.chk_exe = 1'b1; c.aop = aop; c.srcb = sb;
        if (k == 5) c.strb = mk(0, 0, 0, 0, 1, z ^ ins[12], 0, 0, 0);
        q.push_back(c);
        if (k == 5) return;

        if (k == 3 || k == 4) begin
            if (mem_abort == -2) begin
                for (int i = 0; i < int'(ACK_TO) - 1; i++) begin
                    c = blank(ins, z, 1'b0);
                    c.strb = mk(1, k == 4, 0, 0, 0, 0, 0, 0, 0);
                    c.chk_dec = 1'b1; c.imm = imm; c.sfmt = sf;
                    q.push_back(c);
                end
                c = blank(ins, z, 1'b0);
                c.strb = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
                c.chk_dec = 1'b1; c.imm = imm; c.sfmt = sf;
                q.push_back(c);
                return;
            end
            for (int i = 0; i <= dm; i++) begin
                if (i == mem_abort) begin
                    push_reset(1);
                    return;
                end
                c = blank(ins, z, i == dm);
                c.strb = mk(1, k == 4, 0, 0, k == 4 && i == dm, 0, 0, 0, 0);
                c.chk_dec = 1'b1; c.imm = imm; c.sfmt = sf;
                q.push_back(c);
            end
            if (k == 4) return;
        end

        c = blank(ins, z, idle_ack(idle));
        c.strb = mk(0, 0, 0, 1, 1, 0, k == 3, 0, 0);
        c.chk_dec = 1'b1; c.imm = imm; c.sfmt = sf;
        q.push_back(c);
    endtask

    task automatic run_queue();
        cyc_t       c;
        logic [8:0] obs;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            reset = c.rst; mem_ack = c.ack; instr = c.ins; zero = c.z;
            @(negedge clk);
            cyc++;
            obs = {mem_req, mem_we, instr_we, rf_we, pc_we, pc_src, wd_src, mem_err, illegal};
            checks++;
            assert (obs === c.strb) else begin
                fails++;
                $error("FAIL strobes cyc=%0d instr=%h observed=%b expected=%b", cyc, c.ins, obs, c.strb);
            end
            if (c.chk_dec) begin
                checks++;
                assert ({imm_src, store_fmt} === {c.imm, c.sfmt}) else begin
                    fails++;
                    $error("FAIL imm_fmt cyc=%0d instr=%h observed=%b expected=%b",
                           cyc, c.ins, {imm_src, store_fmt}, {c.imm, c.sfmt});
                end
            end
            if (c.chk_exe) begin
                checks++;
                assert ({alu_op, srcb_imm} === {c.aop, c.srcb}) else begin
                    fails++;
                    $error("FAIL exec_ctl cyc=%0d instr=%h observed=%b expected=%b",
                           cyc, c.ins, {alu_op, srcb_imm}, {c.aop, c.srcb});
                end
            end
        end
    endtask

    initial begin
        logic [31:0] pick [8];
        logic [31:0] r, ins;
        int          df, dm, sel, ab;

        reset = 1'b1; mem_ack = 1'b0; instr = '0; zero = 1'b0;

        push_reset(3);
        push_instr(ADDI, 0, 0, 0, 1, -1);
        push_instr(LUI,  0, 0, 0, 2, -1);
        push_instr(BEQ,  1, 0, 0, 2, -1);
        push_instr(BNE,  1, 0, 0, 2, -1);
        push_instr(LW,   0, 0, 3, 2, -1);
        push_fetch_timeout();
        push_instr(ADD,  0, 0, 0, 2, -1);
        push_instr(ADDI, 0, int'(ACK_TO) - 1, 0, 2, -1);
        push_instr(LW,   0, 0, int'(ACK_TO) - 1, 2, -1);
        push_instr(LW,   0, 1, 0, 2, -2);
        push_instr(SW,   0, 0, 5, 2, 2);
        push_fetch_timeout();
        push_instr(ILL,  0, 0, 0, 2, -1);
        push_instr(SW,   0, 2, 1, 2, -1);
        run_queue();

        pick[0] = ADDI; pick[1] = ADD; pick[2] = LUI; pick[3] = BEQ;
        pick[4] = LW;   pick[5] = SW;  pick[6] = ILL; pick[7] = BNE;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 7));
            r   = $urandom();
            ins = pick[sel];
            ins = (sel == 6) ? ins : {r[31:7], ins[6:0]};
            df  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ACK_TO - 1)) : int'($urandom_range(0, 2));
            dm  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ACK_TO - 1)) : int'($urandom_range(0, 2));
            ab  = ($urandom_range(0, 9) == 0) ? -2 : -1;
            if ($urandom_range(0, 11) == 0) push_fetch_timeout();
            push_instr(ins, 1'($urandom_range(0, 1)), df, dm, 2, ab);
        end
        run_queue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
